// File: rtl/draw_request_queue.sv
// draw_request_queue
//
// Buffers 4x4 square draw/erase requests from the game logic and hands them
// one at a time to the square4x4 sequencer. The head entry's x, y and colour
// are held in output registers for the whole burst. The entry is popped only
// after the drawer's plot signal has risen and then fallen again.
//
// Optional feature macro: DRAW_REQUEST_QUEUE_ERASE_EN
//   defined   : the erase bit is stored, and an erase request launches with
//               sq_colour = 3'b000
//   undefined : req_erase is ignored and 18-bit entries are stored
//
// Ports:
//   clk        system clock
//   resetn     asynchronous, active-low reset
//   req_valid  producer presents a request this cycle
//   req_x      square top-left x (0..159)
//   req_y      square top-left y (0..119)
//   req_colour RGB colour
//   req_erase  erase request (only meaningful with the erase macro)
//   req_ready  queue can accept (count < DEPTH)
//   sq_go      start request to the square drawer
//   sq_plot    drawer's plot output, high while pixels are written
//   sq_x       x to the datapath
//   sq_y       y to the datapath
//   sq_colour  colour to the datapath
//   count      queued entries, including the one in flight
//   busy       FSM not idle or queue not empty

module draw_request_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    input  logic [7:0]    req_x,
    input  logic [6:0]    req_y,
    input  logic [2:0]    req_colour,
    input  logic          req_erase,
    output logic          req_ready,
    output logic          sq_go,
    input  logic          sq_plot,
    output logic [7:0]    sq_x,
    output logic [6:0]    sq_y,
    output logic [2:0]    sq_colour,
    output logic [AW:0]   count,
    output logic          busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] DRAW   = 2'd2;

`ifdef DRAW_REQUEST_QUEUE_ERASE_EN
    localparam int EW = 19;
`else
    localparam int EW = 18;
`endif

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic          push;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    // Ready comes from the registered count only, so a pop on the same edge
    // never opens a slot in a full queue within that cycle.
    assign req_ready = (count != FULL_COUNT);
    assign push      = req_valid && req_ready;
    // The head leaves the queue on the first edge that sees plot low after
    // the drawer has started writing pixels.
    assign pop       = (state == DRAW) && !sq_plot;
    assign busy      = (state != IDLE) || (count != '0);
    assign head      = mem[rd_ptr];

`ifdef DRAW_REQUEST_QUEUE_ERASE_EN
    assign wr_entry = {req_erase, req_colour, req_y, req_x};
`else
    logic unused_erase;
    assign unused_erase = req_erase;
    assign wr_entry     = {req_colour, req_y, req_x};
`endif

    // Storage array has no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer handshake. The square outputs are loaded only when leaving
    // IDLE, so they stay frozen for the whole LAUNCH/DRAW burst. sq_go is a
    // flop that mirrors the LAUNCH state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            sq_go     <= 1'b0;
            sq_x      <= '0;
            sq_y      <= '0;
            sq_colour <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        sq_x  <= head[7:0];
                        sq_y  <= head[14:8];
`ifdef DRAW_REQUEST_QUEUE_ERASE_EN
                        sq_colour <= head[18] ? 3'b000 : head[17:15];
`else
                        sq_colour <= head[17:15];
`endif
                        sq_go <= 1'b1;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (sq_plot) begin
                        sq_go <= 1'b0;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (!sq_plot) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    sq_go <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_request_queue.sv
// tb_draw_request_queue
//
// Self-checking bench for draw_request_queue. A directed vector table drives
// the queue with a hand-operated plot line. The remaining sequences use a
// small drawer model: plot rises 2 cycles after go is seen and stays high for
// 16 cycles. A monitor checks burst order, output stability and the relaunch
// gap against an expected-request queue that the bench fills itself.

module tb_draw_request_queue;

    logic       clk;
    logic       resetn;
    logic       req_valid;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic       req_erase;
    logic       req_ready;
    logic       sq_go;
    logic       sq_plot;
    logic [7:0] sq_x;
    logic [6:0] sq_y;
    logic [2:0] sq_colour;
    logic [3:0] count;
    logic       busy;

    logic       model_en;
    logic       model_plot;
    logic       man_plot;
    logic       mon_en;

    int         total;
    int         bad;
    int         bursts_done;
    logic [17:0] exp_q[$];

    assign sq_plot = model_plot | man_plot;

    draw_request_queue #(.DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_erase  (req_erase),
        .req_ready  (req_ready),
        .sq_go      (sq_go),
        .sq_plot    (sq_plot),
        .sq_x       (sq_x),
        .sq_y       (sq_y),
        .sq_colour  (sq_colour),
        .count      (count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       plot;
        logic       ready;
        logic       go;
        logic [3:0] cnt;
        logic       bsy;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid  = v.valid;
        req_x      = v.x;
        req_y      = v.y;
        req_colour = v.c;
        req_erase  = 1'b0;
        man_plot   = v.plot;
    endtask

    task automatic pushReq(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                           input logic e, input logic accept, input logic [2:0] ec);
        req_valid  = 1'b1;
        req_x      = x;
        req_y      = y;
        req_colour = c;
        req_erase  = e;
        if (accept) exp_q.push_back({x, y, ec});
        step();
        req_valid  = 1'b0;
        req_erase  = 1'b0;
    endtask

    task automatic waitBursts(input int target, input int budget);
        for (int i = 0; i < budget && bursts_done < target; i++) step();
        checkOutput("bursts done", bursts_done, target);
    endtask

    // Drawer model: plot rises 2 negedges after go is first seen, for 16 cycles.
    int  mt;
    logic mactive;
    always @(negedge clk) begin
        if (!model_en) begin
            model_plot = 1'b0;
            mactive    = 1'b0;
        end else if (!mactive) begin
            model_plot = 1'b0;
            if (sq_go) begin
                mactive = 1'b1;
                mt      = 1;
            end
        end else begin
            model_plot = (mt >= 2 && mt < 18);
            mt++;
            if (mt > 18) mactive = 1'b0;
        end
    end

    // Burst monitor: head order on each go rise, frozen outputs until the pop,
    // and relaunch exactly one idle cycle after a pop that leaves work queued.
    logic        prev_go;
    logic        in_burst;
    logic        pend_gap;
    logic [17:0] lat;
    always @(posedge clk) begin
        #1;
        if (!mon_en || !resetn) begin
            in_burst = 1'b0;
            pend_gap = 1'b0;
            prev_go  = 1'b0;
        end else begin
            if (pend_gap) begin
                checkOutput("relaunch gap", sq_go, 1);
                pend_gap = 1'b0;
            end
            if (sq_go && !prev_go) begin
                checkOutput("burst expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    lat = exp_q.pop_front();
                    checkOutput("burst head", {sq_x, sq_y, sq_colour}, lat);
                end
                lat      = {sq_x, sq_y, sq_colour};
                in_burst = 1'b1;
            end else if (in_burst) begin
                checkOutput("burst stable", {sq_x, sq_y, sq_colour}, lat);
                if (!sq_go && !sq_plot) begin
                    in_burst = 1'b0;
                    bursts_done++;
                    pend_gap = (count != 0);
                end
            end
            prev_go = sq_go;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   found;
        int   highs;
        int   base;
        logic [3:0] cnt_at;
        logic [2:0] erase_colour;

        total = 0; bad = 0; bursts_done = 0;
        resetn = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
        req_colour = '0; req_erase = 1'b0;
        model_en = 1'b0; man_plot = 1'b0; mon_en = 1'b0;

        //                valid x      y      c     plot rdy go  cnt   bsy ex     ey     ec
        vecs[0]  = '{1'b1, 8'd10, 7'd20, 3'd5, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 8'd0,  7'd0,  3'd0};
        vecs[1]  = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 8'd10, 7'd20, 3'd5};
        vecs[2]  = '{1'b1, 8'd30, 7'd40, 3'd2, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 8'd10, 7'd20, 3'd5};
        vecs[3]  = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 8'd10, 7'd20, 3'd5};
        vecs[4]  = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 8'd10, 7'd20, 3'd5};
        vecs[5]  = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 8'd10, 7'd20, 3'd5};
        vecs[6]  = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 8'd30, 7'd40, 3'd2};
        vecs[7]  = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 8'd30, 7'd40, 3'd2};
        vecs[8]  = '{1'b1, 8'd50, 7'd60, 3'd7, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 8'd30, 7'd40, 3'd2};
        vecs[9]  = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 8'd50, 7'd60, 3'd7};
        vecs[10] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 8'd50, 7'd60, 3'd7};
        vecs[11] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd50, 7'd60, 3'd7};
        vecs[12] = '{1'b0, 8'd0,  7'd0,  3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd50, 7'd60, 3'd7};

        repeat (3) step();
        checkOutput("reset state", {req_ready, sq_go, count, busy, sq_x, sq_y, sq_colour},
                    {1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 7'd0, 3'd0});
        @(negedge clk);
        resetn = 1'b1;

        // Directed table with a hand-driven plot line.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vector %0d", i),
                        {req_ready, sq_go, count, busy, sq_x, sq_y, sq_colour},
                        {vecs[i].ready, vecs[i].go, vecs[i].cnt, vecs[i].bsy,
                         vecs[i].ex, vecs[i].ey, vecs[i].ec});
        end
        req_valid = 1'b0;
        man_plot  = 1'b0;

        mon_en = 1'b1;
        model_en = 1'b1;
        step();

        // Single request: launch one cycle after the push edge.
        base = bursts_done;
        pushReq(8'd10, 7'd20, 3'b101, 1'b0, 1'b1, 3'b101);
        checkOutput("single count", count, 1);
        step();
        checkOutput("single launch", sq_go, 1);
        waitBursts(base + 1, 100);
        step();
        checkOutput("single idle", {count, busy}, 5'd0);

        // Back-to-back pushes.
        base = bursts_done;
        pushReq(8'd1, 7'd2, 3'd3, 1'b0, 1'b1, 3'd3);
        pushReq(8'd100, 7'd101, 3'd4, 1'b0, 1'b1, 3'd4);
        pushReq(8'd159, 7'd119, 3'd6, 1'b0, 1'b1, 3'd6);
        waitBursts(base + 3, 200);
        checkOutput("b2b drained", exp_q.size(), 0);

        // Full queue with the drawer stalled; the ninth push is dropped.
        model_en = 1'b0;
        step();
        base = bursts_done;
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("full ready %0d", i), req_ready, (i < 8) ? 1 : 0);
            pushReq(8'(20 + i), 7'(30 + i), 3'(i), 1'b0, (i < 8), 3'(i));
        end
        checkOutput("full count", {req_ready, count}, {1'b0, 4'd8});
        model_en = 1'b1;
        waitBursts(base + 8, 400);
        checkOutput("full drained", {exp_q.size() == 0, count}, {1'b1, 4'd0});

        // Push on the pop edge with seven entries queued.
        model_en = 1'b0;
        step();
        base = bursts_done;
        for (int i = 0; i < 7; i++) pushReq(8'(60 + i), 7'(70 + i), 3'(7 - i), 1'b0, 1'b1, 3'(7 - i));
        checkOutput("pre-pop count", count, 7);
        man_plot = 1'b1;
        step();
        man_plot = 1'b0;
        pushReq(8'd88, 7'd99, 3'd1, 1'b0, 1'b1, 3'd1);
        checkOutput("push during pop count", count, 7);
        model_en = 1'b1;
        waitBursts(base + 8, 400);
        checkOutput("pop-push drained", {exp_q.size() == 0, count}, {1'b1, 4'd0});

        // Asynchronous reset in the middle of a burst.
        pushReq(8'd11, 7'd12, 3'd1, 1'b0, 1'b1, 3'd1);
        pushReq(8'd13, 7'd14, 3'd2, 1'b0, 1'b1, 3'd2);
        pushReq(8'd15, 7'd16, 3'd3, 1'b0, 1'b1, 3'd3);
        found = 0;
        cnt_at = '0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (!sq_go && sq_plot) begin
                found  = 1;
                cnt_at = count;
            end else begin
                step();
            end
        end
        checkOutput("reached draw", {found[0], cnt_at}, {1'b1, 4'd3});
        #2;
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        checkOutput("async reset", {sq_go, count, busy, req_ready}, {1'b0, 4'd0, 1'b0, 1'b1});
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sq_go || count != 0) highs++;
        end
        checkOutput("no burst after reset", highs, 0);
        mon_en = 1'b1;
        step();
        base = bursts_done;
        pushReq(8'd5, 7'd6, 3'd2, 1'b0, 1'b1, 3'd2);
        waitBursts(base + 1, 100);

        // Erase request.
`ifdef DRAW_REQUEST_QUEUE_ERASE_EN
        erase_colour = 3'b000;
`else
        erase_colour = 3'b111;
`endif
        base = bursts_done;
        pushReq(8'd40, 7'd50, 3'b111, 1'b1, 1'b1, erase_colour);
        waitBursts(base + 1, 100);
        checkOutput("end idle", {exp_q.size() == 0, count, busy}, {1'b1, 4'd0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
